// File: rtl/sseg_scan_scheduler_if.sv
// Load handshake bundle for the 7-segment scan scheduler.
// master offers a 16-bit display value; slave accepts it into its shadow.
interface sseg_scan_scheduler_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/sseg_scan_scheduler.sv
// 4-digit 7-segment scan scheduler: slot timing, dead time, PWM dimming
// and frame-atomic commit of new display values.
module sseg_scan_scheduler #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sseg_scan_scheduler_if.slave ld,
  input  logic [3:0]           digit_mask,
  input  logic [3:0]           duty,
  output logic [1:0]           digit_sel,
  output logic [3:0]           digit_data,
  output logic [3:0]           digit_en,
  output logic                 frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [3:0]    r_pwm;
  logic [15:0]   r_active;
  logic [15:0]   r_shadow;
  logic          r_pending;

  logic          w_wrap;
  logic          w_lit;
  logic          w_bound;
  logic          w_xfer;
  logic          w_bright;
  logic [3:0]    w_pwm;
  logic [3:0]    w_en;

  assign ld.load_ready = !r_pending;

  assign w_wrap  = (r_cnt == CNT_LAST);
  assign w_lit   = (r_cnt >= CNT_DEAD);
  assign w_bound = w_wrap && (r_sel == 2'd3);
  assign w_xfer  = ld.load_valid && !r_pending;

  // pwm phase restarts at the first lit cycle of every slot
  assign w_pwm    = (r_cnt == CNT_DEAD) ? 4'd0 : r_pwm;
  assign w_bright = (duty == 4'd15) || (w_pwm < duty);

  always_comb begin
    w_en = 4'b0000;
    if (w_lit && w_bright && !digit_mask[r_sel])
      w_en[r_sel] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
      r_sel <= 2'd0;
      r_pwm <= 4'd0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap)
        r_sel <= r_sel + 2'd1;
      r_pwm <= w_lit ? w_pwm + 4'd1 : 4'd0;
    end
  end

  // shadow only commits at the frame boundary so a frame is never mixed
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_active  <= 16'h0000;
      r_shadow  <= 16'h0000;
      r_pending <= 1'b0;
    end else if (w_bound) begin
      if (r_pending) begin
        r_active  <= r_shadow;
        r_pending <= 1'b0;
      end else if (w_xfer) begin
        r_active  <= ld.load_data;
      end
    end else if (w_xfer) begin
      r_shadow  <= ld.load_data;
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      digit_sel   <= 2'd0;
      digit_data  <= 4'd0;
      digit_en    <= 4'd0;
      frame_start <= 1'b0;
    end else begin
      digit_sel   <= r_sel;
      digit_data  <= r_active[{r_sel, 2'b00} +: 4];
      digit_en    <= w_en;
      frame_start <= (r_sel == 2'd0) && (r_cnt == '0);
    end
  end

endmodule
